// File: rtl/alu_operand_stage.sv
// ALU operand stage: 2-entry skid FIFO between decode and execute,
// with Mem/Wb operand forwarding evaluated on the held head entry.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   RD1,
  input  logic [WIDTH-1:0]   RD2,
  input  logic [WIDTH-1:0]   ImmExt,
  input  logic               ALUSrc,
  input  logic [2:0]         ALUControlD,
  input  logic [REGBITS-1:0] Rs1,
  input  logic [REGBITS-1:0] Rs2,
  input  logic [REGBITS-1:0] RdD,
  input  logic               RegWriteD,
  input  logic [REGBITS-1:0] MemRd,
  input  logic               MemRegWrite,
  input  logic [WIDTH-1:0]   MemResult,
  input  logic [REGBITS-1:0] WbRd,
  input  logic               WbRegWrite,
  input  logic [WIDTH-1:0]   WbResult,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   SrcA,
  output logic [WIDTH-1:0]   SrcB,
  output logic [2:0]         ALUControl,
  output logic [REGBITS-1:0] RdE,
  output logic               RegWriteE
);

  typedef struct packed {
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   imm;
    logic               alu_src;
    logic [2:0]         ctrl;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [REGBITS-1:0] rd;
    logic               reg_write;
  } entry_t;

  entry_t     slot0;
  entry_t     slot1;
  entry_t     din;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign din = '{
    rd1:       RD1,
    rd2:       RD2,
    imm:       ImmExt,
    alu_src:   ALUSrc,
    ctrl:      ALUControlD,
    rs1:       Rs1,
    rs2:       Rs2,
    rd:        RdD,
    reg_write: RegWriteD
  };

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // slot0 is always the head; slot1 only holds the second entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= din;
          end else if (push) begin
            slot1 <= din;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  logic             mem_a;
  logic             wb_a;
  logic             mem_b;
  logic             wb_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  assign mem_a = MemRegWrite && (MemRd != '0) && (MemRd == slot0.rs1);
  assign wb_a  = WbRegWrite && (WbRd != '0) && (WbRd == slot0.rs1);
  assign mem_b = MemRegWrite && (MemRd != '0) && (MemRd == slot0.rs2);
  assign wb_b  = WbRegWrite && (WbRd != '0) && (WbRd == slot0.rs2);

  // Mem stage is younger than Wb, so it takes priority
  always_comb begin
    fwd_a = slot0.rd1;
    if (mem_a)
      fwd_a = MemResult;
    else if (wb_a)
      fwd_a = WbResult;
  end

  always_comb begin
    fwd_b = slot0.rd2;
    if (mem_b)
      fwd_b = MemResult;
    else if (wb_b)
      fwd_b = WbResult;
  end

  always_comb begin
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;
    RdE        = '0;
    RegWriteE  = 1'b0;
    if (out_valid) begin
      SrcA       = fwd_a;
      SrcB       = slot0.alu_src ? slot0.imm : fwd_b;
      ALUControl = slot0.ctrl;
      RdE        = slot0.rd;
      RegWriteE  = slot0.reg_write;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage.
// Each task drives one scenario and checks outputs inline.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ImmExt;
  logic        ALUSrc;
  logic [2:0]  ALUControlD;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  RdD;
  logic        RegWriteD;
  logic [4:0]  MemRd;
  logic        MemRegWrite;
  logic [31:0] MemResult;
  logic [4:0]  WbRd;
  logic        WbRegWrite;
  logic [31:0] WbResult;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [4:0]  RdE;
  logic        RegWriteE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt),
    .ALUSrc(ALUSrc), .ALUControlD(ALUControlD),
    .Rs1(Rs1), .Rs2(Rs2), .RdD(RdD), .RegWriteD(RegWriteD),
    .MemRd(MemRd), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRd(WbRd), .WbRegWrite(WbRegWrite), .WbResult(WbResult),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .RdE(RdE), .RegWriteE(RegWriteE)
  );

  task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src,
                        input logic [2:0] ctrl, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic rw);
    RD1 = a; RD2 = b; ImmExt = imm; ALUSrc = src; ALUControlD = ctrl;
    Rs1 = r1; Rs2 = r2; RdD = rd; RegWriteD = rw;
  endtask

  task automatic clear_fwd();
    MemRd = '0; MemRegWrite = 1'b0; MemResult = '0;
    WbRd = '0; WbRegWrite = 1'b0; WbResult = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    clear_fwd();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({SrcA, SrcB} !== 64'd0) begin failures++; $display("FAIL reset_src got=%h/%h exp=0/0", SrcA, SrcB); end
    checks++; if ({ALUControl, RdE, RegWriteE} !== 9'd0) begin failures++; $display("FAIL reset_ctrl got=%h/%h/%b exp=0", ALUControl, RdE, RegWriteE); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_op(32'd15, 32'd10, 32'd0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (SrcA !== 32'd15) begin failures++; $display("FAIL basic_srca got=%0d exp=15", SrcA); end
    checks++; if (SrcB !== 32'd10) begin failures++; $display("FAIL basic_srcb got=%0d exp=10", SrcB); end
    checks++; if (ALUControl !== 3'b000) begin failures++; $display("FAIL basic_ctrl got=%b exp=000", ALUControl); end
    checks++; if (RdE !== 5'd3 || RegWriteE !== 1'b1) begin failures++; $display("FAIL basic_rd got=%0d/%b exp=3/1", RdE, RegWriteE); end
    tick();
    checks++; if (out_valid !== 1'b0 || SrcA !== 32'd0) begin failures++; $display("FAIL basic_retire got=%b/%h exp=0/0", out_valid, SrcA); end
  endtask

  task automatic test_forward();
    out_ready = 1'b0;
    set_op(32'h33, 32'h44, 32'd0, 1'b0, 3'b010, 5'd5, 5'd6, 5'd7, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    MemRd = 5'd5; MemRegWrite = 1'b1; MemResult = 32'h99;
    WbRd = 5'd5; WbRegWrite = 1'b1; WbResult = 32'h11;
    #1;
    checks++; if (SrcA !== 32'h99) begin failures++; $display("FAIL fwd_mem_prio got=%h exp=99", SrcA); end
    MemRegWrite = 1'b0;
    #1;
    checks++; if (SrcA !== 32'h11) begin failures++; $display("FAIL fwd_wb got=%h exp=11", SrcA); end
    WbRd = 5'd6; WbResult = 32'h55;
    #1;
    checks++; if (SrcA !== 32'h33) begin failures++; $display("FAIL fwd_none_a got=%h exp=33", SrcA); end
    checks++; if (SrcB !== 32'h55) begin failures++; $display("FAIL fwd_wb_b got=%h exp=55", SrcB); end
    WbRegWrite = 1'b0;
    #1;
    checks++; if (SrcB !== 32'h44) begin failures++; $display("FAIL fwd_none_b got=%h exp=44", SrcB); end
    out_ready = 1'b1;
    tick();
    clear_fwd();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_retire got=%b exp=0", out_valid); end
  endtask

  task automatic test_x0_imm();
    out_ready = 1'b0;
    set_op(32'd7, 32'h21, 32'hFFFFFFFC, 1'b1, 3'b001, 5'd0, 5'd3, 5'd9, 1'b0);
    MemRd = 5'd0; MemRegWrite = 1'b1; MemResult = 32'hDEAD;
    WbRd = 5'd3; WbRegWrite = 1'b1; WbResult = 32'hBEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (SrcA !== 32'd7) begin failures++; $display("FAIL x0_srca got=%h exp=7", SrcA); end
    checks++; if (SrcB !== 32'hFFFFFFFC) begin failures++; $display("FAIL imm_srcb got=%h exp=fffffffc", SrcB); end
    checks++; if (ALUControl !== 3'b001 || RdE !== 5'd9 || RegWriteE !== 1'b0) begin failures++; $display("FAIL imm_pass got=%b/%0d/%b exp=001/9/0", ALUControl, RdE, RegWriteE); end
    out_ready = 1'b1;
    tick();
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_op(32'd1, 32'd2, 32'd0, 1'b0, 3'b011, 5'd1, 5'd2, 5'd4, 1'b1);
    in_valid = 1'b1;
    tick();
    checks++; if (ALUControl !== 3'b011) begin failures++; $display("FAIL b2b_first got=%b exp=011", ALUControl); end
    set_op(32'd3, 32'd4, 32'd0, 1'b0, 3'b100, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (ALUControl !== 3'b100 || SrcA !== 32'd3) begin failures++; $display("FAIL b2b_replace got=%b/%0d exp=100/3", ALUControl, SrcA); end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_count1 got=%b/%b exp=1/1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_op(32'd1, 32'd1, 32'd0, 1'b0, 3'b101, 5'd1, 5'd1, 5'd1, 1'b1);
    in_valid = 1'b1;
    tick();
    set_op(32'd2, 32'd2, 32'd0, 1'b0, 3'b110, 5'd2, 5'd2, 5'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    checks++; if (ALUControl !== 3'b101) begin failures++; $display("FAIL bp_head got=%b exp=101", ALUControl); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_comb got=%b exp=0", in_ready); end
    tick();
    checks++; if (ALUControl !== 3'b110 || RdE !== 5'd2) begin failures++; $display("FAIL bp_second got=%b/%0d exp=110/2", ALUControl, RdE); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_op(32'hA, 32'hB, 32'd0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_two got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (SrcA !== 32'd0 || ALUControl !== 3'd0) begin failures++; $display("FAIL flush_zero got=%h/%b exp=0/0", SrcA, ALUControl); end
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_wins got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(32'h77, 32'h88, 32'd0, 1'b0, 3'b101, 5'd1, 5'd2, 5'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if ({SrcA, SrcB} !== 64'd0 || {ALUControl, RdE, RegWriteE} !== 9'd0) begin failures++; $display("FAIL rst_mid_out got=%h/%h/%b exp=0", SrcA, SrcB, ALUControl); end
    @(negedge clk);
    rst_n = 1'b1;
    set_op(32'h42, 32'h43, 32'd0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || SrcA !== 32'h42) begin failures++; $display("FAIL rst_accept got=%b/%h exp=1/42", out_valid, SrcA); end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_x0_imm();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width of operands and results.
REQ-002 SHALL have parameter REGBITS, default 5, the width of register indices.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the decode-side handshake.
REQ-007 SHALL have ports RD1 and RD2 (input, WIDTH), register-file read data.
REQ-008 SHALL have port ImmExt (input, WIDTH), the sign-extended immediate.
REQ-009 SHALL have port ALUSrc (input, 1); when 1, SrcB takes ImmExt.
REQ-010 SHALL have port ALUControlD (input, 3), the ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 srl.
REQ-011 SHALL have ports Rs1, Rs2, RdD (input, REGBITS) and RegWriteD (input, 1).
REQ-012 SHALL have ports MemRd (input, REGBITS), MemRegWrite (input, 1) and MemResult (input, WIDTH), the forwarding source one stage down.
REQ-013 SHALL have ports WbRd (input, REGBITS), WbRegWrite (input, 1) and WbResult (input, WIDTH), the forwarding source two stages down.
REQ-014 SHALL have port flush (input, 1), a synchronous discard of all held entries.
REQ-015 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the ALU-side handshake.
REQ-016 SHALL have ports SrcA and SrcB (output, WIDTH), the ALU operands.
REQ-017 SHALL have ports ALUControl (output, 3), RdE (output, REGBITS) and RegWriteE (output, 1).

Function
REQ-018 SHALL hold decoded operations in a 2-entry in-order FIFO (skid buffer) with an occupancy count of 0..2.
REQ-019 SHALL drive in_ready = (count < 2); in_ready SHALL not depend combinationally on out_ready.
REQ-020 SHALL accept an entry when in_valid && in_ready, and retire the head when out_valid && out_ready.
REQ-021 SHALL drive out_valid = (count != 0); an accepted entry SHALL be visible on the outputs on the first cycle after acceptance (1-cycle latency).
REQ-022 SHALL handle a simultaneous accept and retire at count 1 by replacing the head, with count staying 1; at count 0 the accept proceeds normally and no retire occurs.
REQ-023 SHALL, when flush=1, set count to 0 at the next edge, discarding any same-cycle accept (flush wins).
REQ-024 SHALL compute forwarded A as: MemResult if MemRegWrite && MemRd != 0 && MemRd == head.Rs1; else WbResult if WbRegWrite && WbRd != 0 && WbRd == head.Rs1; else head.RD1.
REQ-025 SHALL compute forwarded B the same way using head.Rs2 and head.RD2.
REQ-026 SHALL drive SrcA with forwarded A, and SrcB with head.ImmExt when head.ALUSrc = 1, otherwise with forwarded B.
REQ-027 SHALL evaluate forwarding combinationally every cycle on the held head, so a stalled entry picks up newly arriving results.
REQ-028 SHALL pass ALUControl, RdE and RegWriteE through from the head entry.
REQ-029 SHALL, when count = 0, drive SrcA, SrcB, ALUControl, RdE and RegWriteE to 0.
REQ-030 SHALL apply no arithmetic; all operand widths are WIDTH with no truncation or extension.

Reset
REQ-031 SHALL, while rst_n = 0, immediately set count to 0 and clear all entry storage, independent of clk.
REQ-032 SHALL, during and after reset, drive out_valid = 0, in_ready = 1, and SrcA, SrcB, ALUControl, RdE and RegWriteE to 0.
REQ-033 SHALL lose held entries when reset is asserted mid-operation, and SHALL accept new input from the first clock edge after rst_n rises.

Verification
REQ-034 Basic: RD1=15, RD2=10, ALUSrc=0, ALUControlD=000, out_ready=1 -> next cycle out_valid=1, SrcA=15, SrcB=10, ALUControl=000.
REQ-035 Forwarding priority: head.Rs1=5, MemRd=5, MemRegWrite=1, MemResult=0x99, WbRd=5, WbRegWrite=1, WbResult=0x11 -> SrcA=0x99; with MemRegWrite=0 -> SrcA=0x11.
REQ-036 x0 and immediate: Rs1=0, MemRd=0, MemRegWrite=1, RD1=7 -> SrcA=7; ALUSrc=1, ImmExt=0xFFFFFFFC -> SrcB=0xFFFFFFFC regardless of forwarding.
REQ-037 Backpressure: out_ready=0 and two ops accepted (ALUControlD=101, then 110) -> in_ready=0; then out_ready=1 -> ops emerge 101 then 110 on consecutive cycles, and in_ready returns to 1.
REQ-038 Flush and reset: with 2 entries held, flush=1 for one cycle -> next cycle out_valid=0 and in_ready=1; rst_n pulsed low mid-stream -> outputs 0 asynchronously.
